// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial signed BCD adder/subtractor.
// Holds the digit count, the digit width, the largest legal BCD digit,
// the controller state encoding and a nine's-complement helper.
package bcd_pkg;

    localparam int unsigned NDIG    = 3;
    localparam int unsigned DIG_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StPass1,
        StEval,
        StPass2,
        StDone
    } state_e;

    // Nine's complement of a single legal BCD digit.
    function automatic logic [3:0] nines(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder.
// Ports:
//   a, b  : BCD digits (0..9)
//   cin   : carry in
//   s     : BCD sum digit
//   cout  : decimal carry out
// A binary ripple of full-adder cells forms a+b+cin, then a +6 correction
// (half-adder style add of 0110) is applied whenever the binary sum exceeds 9.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] z;
    logic [4:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            z[i]     = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    // Decimal carry: binary carry out, or binary sum in 10..15.
    assign cout = c[4] | (z[3] & (z[2] | z[1]));

    // +6 correction; the carry out of this add is the decimal carry and is dropped.
    assign s = z + {1'b0, cout, cout, 1'b0};

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial controller for a signed sign-magnitude BCD adder/subtractor.
// One shared bcd_digit_add is reused for every digit. Mixed-sign operations
// use ten's complement; a negative raw result gets a second recomplement pass.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start            : request pulse, sampled only while busy = 0
//   op               : 0 = A+B, 1 = A-B
//   a_sign, a_mag    : operand A (sign 1 = negative, BCD magnitude, digit 0 in [3:0])
//   b_sign, b_mag    : operand B, same format
//   busy             : operation in progress
//   done             : one-cycle pulse, results valid from this cycle
//   r_sign, r_mag    : result, held until the next accepted start or reset
//   ovf              : true result magnitude exceeds the representable range
//   invalid          : an operand digit was greater than 9
module bcd_addsub_seq #(
    parameter int unsigned NDIG = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic                a_sign,
    input  logic [4*NDIG-1:0]   a_mag,
    input  logic                b_sign,
    input  logic [4*NDIG-1:0]   b_mag,
    output logic                busy,
    output logic                done,
    output logic                r_sign,
    output logic [4*NDIG-1:0]   r_mag,
    output logic                ovf,
    output logic                invalid
);

    import bcd_pkg::*;

    localparam int unsigned W     = 4 * NDIG;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_sh;      // operand A, or PASS1 sum during PASS2
    logic [W-1:0]     b_sh;
    logic [W-1:0]     s_sh;      // result digits shift in at the top
    logic             carry;     // registered carry between digits
    logic             sub_path;
    logic             a_sign_q;
    logic             bs_q;

    logic             bs_in;
    logic             ops_invalid;
    logic             accept;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic [3:0]       add_s;
    logic             add_cout;
    logic [W-1:0]     s_next;

    always_comb begin
        bs_in       = b_sign ^ op;
        ops_invalid = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (a_mag[4*i +: 4] > BCD_MAX || b_mag[4*i +: 4] > BCD_MAX) begin
                ops_invalid = 1'b1;
            end
        end
        accept = start && !busy && (state == StIdle || state == StDone);
    end

    // Adder operand selection: PASS1 adds A to B (or to 9's complement of B on the
    // subtract path); PASS2 recomplements the PASS1 sum held in a_sh.
    always_comb begin
        add_a = a_sh[3:0];
        add_b = b_sh[3:0];
        if (state == StPass2) begin
            add_a = nines(a_sh[3:0]);
            add_b = 4'd0;
        end else if (sub_path) begin
            add_b = nines(b_sh[3:0]);
        end
    end

    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .s    (add_s),
        .cout (add_cout)
    );

    assign s_next = W'({add_s, s_sh} >> DIG_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            idx      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            carry    <= 1'b0;
            sub_path <= 1'b0;
            a_sign_q <= 1'b0;
            bs_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            ovf      <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    state <= StIdle;
                    if (accept) begin
                        a_sh     <= a_mag;
                        b_sh     <= b_mag;
                        s_sh     <= '0;
                        a_sign_q <= a_sign;
                        bs_q     <= bs_in;
                        sub_path <= a_sign ^ bs_in;
                        // Ten's complement on the subtract path starts with carry 1.
                        carry    <= a_sign ^ bs_in;
                        idx      <= '0;
                        ovf      <= 1'b0;
                        invalid  <= 1'b0;
                        if (ops_invalid) begin
                            state   <= StDone;
                            done    <= 1'b1;
                            invalid <= 1'b1;
                            r_mag   <= '0;
                            r_sign  <= 1'b0;
                        end else begin
                            state <= StPass1;
                            busy  <= 1'b1;
                        end
                    end
                end
                StPass1: begin
                    a_sh  <= a_sh >> DIG_W;
                    b_sh  <= b_sh >> DIG_W;
                    s_sh  <= s_next;
                    carry <= add_cout;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= StEval;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                StEval: begin
                    if (sub_path && !carry) begin
                        // |B| > |A|: the sum is the ten's complement of the answer.
                        state <= StPass2;
                        a_sh  <= s_sh;
                        s_sh  <= '0;
                        carry <= 1'b1;
                        idx   <= '0;
                    end else begin
                        state  <= StDone;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        r_mag  <= s_sh;
                        r_sign <= (s_sh == '0) ? 1'b0 : a_sign_q;
                        ovf    <= !sub_path && carry;
                    end
                end
                StPass2: begin
                    a_sh  <= a_sh >> DIG_W;
                    s_sh  <= s_next;
                    carry <= add_cout;
                    if (idx == IDX_LAST) begin
                        idx    <= '0;
                        state  <= StDone;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        r_mag  <= s_next;
                        r_sign <= (s_next == '0) ? 1'b0 : bs_q;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
